// File: rtl/sha1_pkg.sv
// Shared SHA-1 definitions: FSM states, working-variable bundle, constants
// and the per-round boolean function.
package sha1_pkg;

    typedef enum logic [2:0] {IDLE, LOAD, PAD, HASH, UPDATE, DONE} sha1_state_e;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] c;
        logic [31:0] d;
        logic [31:0] e;
    } sha1_vars_t;

    localparam sha1_vars_t SHA1_IV = 160'h67452301_EFCDAB89_98BADCFE_10325476_C3D2E1F0;

    localparam logic [31:0] K0 = 32'h5A827999;
    localparam logic [31:0] K1 = 32'h6ED9EBA1;
    localparam logic [31:0] K2 = 32'h8F1BBCDC;
    localparam logic [31:0] K3 = 32'hCA62C1D6;

    function automatic logic [31:0] sha1_f(input logic [6:0] t, input logic [31:0] b,
                                           input logic [31:0] c, input logic [31:0] d);
        logic [31:0] f;
        if (t < 7'd20)
            f = (b & c) | (~b & d);
        else if (t < 7'd40 || t >= 7'd60)
            f = b ^ c ^ d;
        else
            f = (b & c) | (b & d) | (c & d);
        return f;
    endfunction

    function automatic logic [31:0] sha1_k(input logic [6:0] t);
        logic [31:0] k;
        if (t < 7'd20)
            k = K0;
        else if (t < 7'd40)
            k = K1;
        else if (t < 7'd60)
            k = K2;
        else
            k = K3;
        return k;
    endfunction

endpackage

// File: rtl/sha1_round.sv
// One combinational SHA-1 round; chained ROUNDS_PER_CYCLE times by sha1_stream.
module sha1_round
    import sha1_pkg::*;
(
    input  sha1_vars_t  s_i,
    input  logic [31:0] w_i,
    input  logic [6:0]  t_i,
    output sha1_vars_t  s_o
);

    logic [31:0] temp;

    always_comb begin
        temp  = {s_i.a[26:0], s_i.a[31:27]} + sha1_f(t_i, s_i.b, s_i.c, s_i.d)
              + s_i.e + sha1_k(t_i) + w_i;
        s_o.a = temp;
        s_o.b = s_i.a;
        s_o.c = {s_i.b[1:0], s_i.b[31:2]};
        s_o.d = s_i.c;
        s_o.e = s_i.d;
    end

endmodule

// File: rtl/sha1_stream.sv
// Streaming SHA-1 engine: word loader, internal padding, multi-block chaining
// and a configurable number of rounds per clock.
module sha1_stream
    import sha1_pkg::*;
#(
    parameter int unsigned ROUNDS_PER_CYCLE = 1,
    parameter int unsigned TAG_W            = 32,
    parameter int unsigned LEN_W            = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_i,
    input  logic [TAG_W-1:0] tag_i,
    input  logic [31:0]      data_i,
    input  logic             valid_i,
    input  logic             last_i,
    input  logic [2:0]       last_bytes_i,
    output logic             ready_o,
    output logic             busy_o,
    output logic             done_o,
    output logic [159:0]     result_o,
    output logic [TAG_W-1:0] tag_o
);

    localparam bit RPC_LEGAL = (ROUNDS_PER_CYCLE >= 1) && (ROUNDS_PER_CYCLE <= 20)
                             && ((ROUNDS_PER_CYCLE >= 1) ? ((80 % ROUNDS_PER_CYCLE) == 0) : 1'b0);
    localparam int unsigned LAST_T = 80 - ROUNDS_PER_CYCLE;

    if (!RPC_LEGAL) begin : g_bad_rpc
        $error("sha1_stream: ROUNDS_PER_CYCLE must divide 80 and be at most 20");
    end
    if (LEN_W < 8 || LEN_W > 64) begin : g_bad_len
        $error("sha1_stream: LEN_W must be in 8..64");
    end

    sha1_state_e      state_q, state_d;
    sha1_vars_t       h_q, v_q, h_sum;
    logic [31:0]      w_q    [16];
    logic [31:0]      w_next [16];
    logic [31:0]      pad_w  [16];
    logic [31:0]      w_rnd  [ROUNDS_PER_CYCLE];
    sha1_vars_t       chain  [ROUNDS_PER_CYCLE+1];
    logic [3:0]       idx_q, last_idx_q;
    logic [2:0]       last_bytes_q, lb_clamp;
    logic [6:0]       t_q, pad_pos;
    logic [LEN_W-1:0] len_q;
    logic [63:0]      len64;
    logic             extra_q, final_q, marker_q, xfer;
    logic [TAG_W-1:0] tag_q, tag_out_q;
    logic [159:0]     result_q;

    assign xfer     = valid_i && (state_q == LOAD);
    assign lb_clamp = (last_bytes_i > 3'd4) ? 3'd4 : last_bytes_i;

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start_i) state_d = LOAD;
            LOAD:    if (xfer) begin
                         if (last_i)              state_d = PAD;
                         else if (idx_q == 4'd15) state_d = HASH;
                     end
            PAD:     state_d = HASH;
            HASH:    if (t_q == 7'(LAST_T)) state_d = UPDATE;
            UPDATE:  if (extra_q)      state_d = PAD;
                     else if (final_q) state_d = DONE;
                     else              state_d = LOAD;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Message schedule expanded in place; later rounds of a cycle see words
    // produced by earlier rounds of the same cycle.
    always_comb begin
        logic [6:0]  t;
        logic [3:0]  j;
        logic [31:0] x;
        t      = '0;
        j      = '0;
        x      = '0;
        w_next = w_q;
        w_rnd  = '{default: '0};
        for (int unsigned r = 0; r < ROUNDS_PER_CYCLE; r++) begin
            t = t_q + 7'(r);
            j = t[3:0];
            if (t < 7'd16) begin
                w_rnd[r] = w_next[j];
            end else begin
                x         = w_next[j + 4'd13] ^ w_next[j + 4'd8] ^ w_next[j + 4'd2] ^ w_next[j];
                w_rnd[r]  = {x[30:0], x[31]};
                w_next[j] = {x[30:0], x[31]};
            end
        end
    end

    assign chain[0] = v_q;
    for (genvar g = 0; g < ROUNDS_PER_CYCLE; g++) begin : g_round
        sha1_round u_round (
            .s_i (chain[g]),
            .w_i (w_rnd[g]),
            .t_i (t_q + 7'(g)),
            .s_o (chain[g+1])
        );
    end

    always_comb begin
        h_sum.a = h_q.a + v_q.a;
        h_sum.b = h_q.b + v_q.b;
        h_sum.c = h_q.c + v_q.c;
        h_sum.d = h_q.d + v_q.d;
        h_sum.e = h_q.e + v_q.e;
    end

    // pad_pos is the byte offset of the 0x80 marker; 64 means it spills into the extra block.
    always_comb begin
        logic [6:0] off;
        logic [7:0] byte_v;
        off     = '0;
        byte_v  = '0;
        pad_w   = '{default: '0};
        pad_pos = {1'b0, last_idx_q, 2'b00} + 7'(last_bytes_q);
        len64   = 64'(len_q);
        for (int unsigned j = 0; j < 16; j++) begin
            for (int unsigned b = 0; b < 4; b++) begin
                off = 7'(4 * j + b);
                if (extra_q)
                    byte_v = (j == 0 && b == 0 && marker_q) ? 8'h80 : 8'h00;
                else if (off < pad_pos)
                    byte_v = w_q[j][31 - 8 * b -: 8];
                else if (off == pad_pos)
                    byte_v = 8'h80;
                else
                    byte_v = 8'h00;
                pad_w[j][31 - 8 * b -: 8] = byte_v;
            end
        end
        if (extra_q || pad_pos < 7'd56) begin
            pad_w[14] = len64[63:32];
            pad_w[15] = len64[31:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            h_q          <= '0;
            v_q          <= '0;
            w_q          <= '{default: '0};
            idx_q        <= '0;
            last_idx_q   <= '0;
            last_bytes_q <= '0;
            t_q          <= '0;
            len_q        <= '0;
            extra_q      <= 1'b0;
            final_q      <= 1'b0;
            marker_q     <= 1'b0;
            tag_q        <= '0;
            tag_out_q    <= '0;
            result_q     <= '0;
        end else begin
            state_q <= state_d;
            case (state_q)
                IDLE: if (start_i) begin
                    tag_q    <= tag_i;
                    h_q      <= SHA1_IV;
                    idx_q    <= '0;
                    len_q    <= '0;
                    extra_q  <= 1'b0;
                    final_q  <= 1'b0;
                    marker_q <= 1'b0;
                end
                LOAD: if (xfer) begin
                    w_q[idx_q] <= data_i;
                    idx_q      <= idx_q + 4'd1;
                    if (last_i) begin
                        len_q        <= len_q + LEN_W'({lb_clamp, 3'b000});
                        last_idx_q   <= idx_q;
                        last_bytes_q <= lb_clamp;
                    end else begin
                        len_q <= len_q + LEN_W'(32);
                    end
                end
                PAD: begin
                    w_q <= pad_w;
                    if (extra_q) begin
                        extra_q <= 1'b0;
                        final_q <= 1'b1;
                    end else if (pad_pos < 7'd56) begin
                        final_q <= 1'b1;
                    end else begin
                        extra_q  <= 1'b1;
                        marker_q <= (pad_pos == 7'd64);
                    end
                end
                HASH: begin
                    v_q <= chain[ROUNDS_PER_CYCLE];
                    w_q <= w_next;
                    t_q <= t_q + 7'(ROUNDS_PER_CYCLE);
                end
                UPDATE: begin
                    h_q   <= h_sum;
                    idx_q <= '0;
                    if (final_q) begin
                        result_q  <= h_sum;
                        tag_out_q <= tag_q;
                    end
                end
                default: ;
            endcase
            if (state_d == HASH && state_q != HASH) begin
                v_q <= h_q;
                t_q <= '0;
            end
        end
    end

    assign ready_o  = (state_q == LOAD);
    assign busy_o   = (state_q != IDLE);
    assign done_o   = (state_q == DONE);
    assign result_o = result_q;
    assign tag_o    = tag_out_q;

endmodule

// File: tb/tb_sha1_stream.sv
// Scoreboard bench for sha1_stream at 1, 4 and 20 rounds per cycle using
// known SHA-1 vectors, backpressure, ignored starts and mid-hash reset.
module tb_sha1_stream;

    localparam int NDUT = 3;

    localparam logic [159:0] DIG_ABC   = 160'ha9993e36_4706816a_ba3e2571_7850c26c_9cd0d89d;
    localparam logic [159:0] DIG_EMPTY = 160'hda39a3ee_5e6b4b0d_3255bfef_95601890_afd80709;
    localparam logic [159:0] DIG_1234  = 160'h7110eda4_d09e062a_a5e4a390_b0a572ac_0d2c0220;
    localparam logic [159:0] DIG_FOX   = 160'h2fd4e1c6_7a2d28fc_ed849ee1_bb76e739_1b93eb12;
    localparam logic [159:0] DIG_56    = 160'h84983e44_1c3bd26e_baae4aa1_f95129e5_e54670f1;
    localparam logic [159:0] DIG_112   = 160'ha49b2446_a02c645b_f419f995_b6709125_3a04a259;

    typedef struct {
        int           d;
        logic [159:0] dig;
        logic [31:0]  tag;
        int           acc;
        int           lat;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst;
    logic         start_s  [NDUT];
    logic [31:0]  tag_s    [NDUT];
    logic [31:0]  data_s   [NDUT];
    logic         valid_s  [NDUT];
    logic         last_s   [NDUT];
    logic [2:0]   lb_s     [NDUT];
    logic         ready_s  [NDUT];
    logic         busy_s   [NDUT];
    logic         done_s   [NDUT];
    logic [159:0] result_s [NDUT];
    logic [31:0]  tago_s   [NDUT];

    exp_t         sb [$];
    exp_t         mon_e;
    byte unsigned msg [$];
    int           cyc    = 0;
    int           checks = 0;
    int           errors = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    for (genvar g = 0; g < NDUT; g++) begin : g_dut
        localparam int unsigned RPC = (g == 0) ? 1 : (g == 1) ? 4 : 20;
        sha1_stream #(.ROUNDS_PER_CYCLE(RPC), .TAG_W(32), .LEN_W(64)) u_dut (
            .clk          (clk),
            .rst          (rst),
            .start_i      (start_s[g]),
            .tag_i        (tag_s[g]),
            .data_i       (data_s[g]),
            .valid_i      (valid_s[g]),
            .last_i       (last_s[g]),
            .last_bytes_i (lb_s[g]),
            .ready_o      (ready_s[g]),
            .busy_o       (busy_s[g]),
            .done_o       (done_s[g]),
            .result_o     (result_s[g]),
            .tag_o        (tago_s[g])
        );
    end

    function automatic int r_of(input int d);
        return (d == 0) ? 80 : (d == 1) ? 20 : 4;
    endfunction

    task automatic check(input string name, input logic [159:0] act, input logic [159:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        for (int d = 0; d < NDUT; d++) begin
            if (done_s[d] === 1'b1) begin
                if (sb.size() == 0) begin
                    check("unexpected_done", 160'(done_s[d]), 160'(0));
                end else begin
                    mon_e = sb.pop_front();
                    check("done_dut", 160'(d), 160'(mon_e.d));
                    check("digest", result_s[d], mon_e.dig);
                    check("tag", 160'(tago_s[d]), 160'(mon_e.tag));
                    check("latency", 160'(cyc - mon_e.acc), 160'(mon_e.lat));
                end
            end
        end
    end

    task automatic set_str(input string s);
        msg.delete();
        for (int i = 0; i < s.len(); i++) msg.push_back(s[i]);
    endtask

    // Overlapping letter runs: groups of glen letters, each group shifted by one.
    task automatic set_pattern(input int groups, input int glen);
        msg.delete();
        for (int g = 0; g < groups; g++)
            for (int p = 0; p < glen; p++) msg.push_back(8'(97 + g + p));
    endtask

    task automatic run_msg(input int d, input logic [31:0] tg, input logic [159:0] dig,
                           input int lat, input bit gaps, input bit noise,
                           input int lb_force, input bit expect_done);
        int          nw, lb, i, budget;
        logic [31:0] w;
        bit          v;
        exp_t        e;
        nw = (msg.size() + 3) / 4;
        if (nw == 0) nw = 1;
        lb = msg.size() - 4 * (nw - 1);
        @(negedge clk);
        start_s[d] = 1'b1; tag_s[d] = tg; valid_s[d] = 1'b1;
        data_s[d] = 32'hDEADBEEF; last_s[d] = 1'b1; lb_s[d] = 3'd4;
        @(negedge clk);
        start_s[d] = 1'b0; valid_s[d] = 1'b0; last_s[d] = 1'b0;
        check("ready_after_start", 160'(ready_s[d]), 160'(1));
        check("busy_after_start", 160'(busy_s[d]), 160'(1));
        i = 0;
        budget = 0;
        while (i < nw && budget < 3000) begin
            for (int b = 0; b < 4; b++)
                w[31 - 8 * b -: 8] = (4 * i + b < msg.size()) ? msg[4 * i + b] : 8'hA5;
            v = !(gaps && $urandom_range(0, 2) == 0);
            valid_s[d] = v;
            data_s[d]  = w;
            last_s[d]  = (i == nw - 1);
            lb_s[d]    = (i == nw - 1) ? ((lb_force >= 0) ? 3'(lb_force) : 3'(lb))
                                       : 3'($urandom_range(0, 7));
            if (noise) begin
                start_s[d] = 1'($urandom_range(0, 1));
                tag_s[d]   = 32'hBAD0BAD0;
            end
            if (v && ready_s[d]) begin
                if (i == nw - 1 && expect_done) begin
                    e.d = d; e.dig = dig; e.tag = tg; e.acc = cyc; e.lat = lat;
                    sb.push_back(e);
                end
                i++;
            end
            @(negedge clk);
            budget++;
        end
        valid_s[d] = 1'b0; last_s[d] = 1'b0; start_s[d] = 1'b0;
        if (i < nw) check("load_timeout", 160'(i), 160'(nw));
    endtask

    task automatic finish_msg(input int d, input logic [159:0] dig, input logic [31:0] tg);
        int n;
        n = 0;
        while (busy_s[d] && n < 1000) begin
            @(negedge clk);
            n++;
        end
        if (busy_s[d]) check("busy_timeout", 160'(busy_s[d]), 160'(0));
        repeat (3) @(negedge clk);
        check("sb_drained", 160'(sb.size()), 160'(0));
        check("result_held", result_s[d], dig);
        check("tag_held", 160'(tago_s[d]), 160'(tg));
    endtask

    task automatic check_reset_outputs(input int d);
        check("rst_ready", 160'(ready_s[d]), 160'(0));
        check("rst_busy", 160'(busy_s[d]), 160'(0));
        check("rst_done", 160'(done_s[d]), 160'(0));
        check("rst_result", result_s[d], 160'(0));
        check("rst_tag", 160'(tago_s[d]), 160'(0));
    endtask

    initial begin
        for (int d = 0; d < NDUT; d++) begin
            start_s[d] = 1'b0; tag_s[d] = '0; data_s[d] = '0;
            valid_s[d] = 1'b0; last_s[d] = 1'b0; lb_s[d] = '0;
        end
        rst = 1'b1;
        repeat (3) @(negedge clk);
        for (int d = 0; d < NDUT; d++) check_reset_outputs(d);
        rst = 1'b0;

        for (int d = 0; d < NDUT; d++) begin
            set_str("abc");
            run_msg(d, 32'(32'hA0000000 + d), DIG_ABC, r_of(d) + 3, 1'b0, 1'b0, -1, 1'b1);
            finish_msg(d, DIG_ABC, 32'(32'hA0000000 + d));
        end

        set_str("");
        run_msg(0, 32'h00000E00, DIG_EMPTY, r_of(0) + 3, 1'b0, 1'b0, -1, 1'b1);
        finish_msg(0, DIG_EMPTY, 32'h00000E00);
        set_str("1234");
        run_msg(0, 32'h10001000, DIG_1234, r_of(0) + 3, 1'b0, 1'b0, -1, 1'b1);
        finish_msg(0, DIG_1234, 32'h10001000);
        set_str("1234");
        run_msg(1, 32'h10001001, DIG_1234, r_of(1) + 3, 1'b0, 1'b0, 7, 1'b1);
        finish_msg(1, DIG_1234, 32'h10001001);
        set_str("The quick brown fox jumps over the lazy dog");
        run_msg(2, 32'h0000F0F0, DIG_FOX, r_of(2) + 3, 1'b1, 1'b0, -1, 1'b1);
        finish_msg(2, DIG_FOX, 32'h0000F0F0);

        for (int d = 0; d < NDUT; d++) begin
            set_pattern(14, 4);
            run_msg(d, 32'(32'h56000000 + d), DIG_56, 2 * r_of(d) + 5, 1'b0, 1'b0, -1, 1'b1);
            finish_msg(d, DIG_56, 32'(32'h56000000 + d));
            set_pattern(14, 8);
            run_msg(d, 32'(32'h11200000 + d), DIG_112, r_of(d) + 3, d != 0, 1'b0, -1, 1'b1);
            finish_msg(d, DIG_112, 32'(32'h11200000 + d));
        end

        set_pattern(14, 4);
        run_msg(2, 32'h0BAC0002, DIG_56, 2 * r_of(2) + 5, 1'b1, 1'b1, -1, 1'b1);
        finish_msg(2, DIG_56, 32'h0BAC0002);
        set_pattern(14, 8);
        run_msg(0, 32'h0BAC0000, DIG_112, r_of(0) + 3, 1'b1, 1'b1, -1, 1'b1);
        finish_msg(0, DIG_112, 32'h0BAC0000);

        set_str("abc");
        run_msg(0, 32'h00000005, DIG_ABC, 0, 1'b0, 1'b0, -1, 1'b0);
        repeat (10) @(negedge clk);
        check("busy_mid_hash", 160'(busy_s[0]), 160'(1));
        rst = 1'b1;
        @(negedge clk);
        check_reset_outputs(0);
        rst = 1'b0;
        set_str("abc");
        run_msg(0, 32'h00000006, DIG_ABC, r_of(0) + 3, 1'b0, 1'b0, -1, 1'b1);
        finish_msg(0, DIG_ABC, 32'h00000006);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, errors so far %0d", errors);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/sha1_stream.md
# sha1_stream

Parametrised streaming SHA-1 engine, the successor to `sha1_dfa`. It accepts messages of any byte length as a big-endian 32-bit word stream with a valid/ready handshake. Padding and multi-block chaining are done internally, and the number of rounds per clock is set by a parameter. It sits on the core's accelerator port and returns a 160-bit digest with the caller's address tag.

## Interface
- `ROUNDS_PER_CYCLE`, default 1: SHA-1 rounds evaluated per HASH cycle. Legal values are the divisors of 80 up to 20 (1, 2, 4, 5, 8, 10, 16, 20); any other value is an elaboration error.
- `TAG_W`, default 32: width of the address tag passed through.
- `LEN_W`, default 64: width of the message bit-length counter. Range 8..64; the value is zero-extended to 64 bits in the length field.

Ports:
- `clk` in 1: the single clock.
- `rst` in 1: reset, synchronous, active-high.
- `start_i` in 1: begin a new message. Sampled only in IDLE.
- `tag_i` in TAG_W: tag, latched on an accepted `start_i`.
- `data_i` in 32: message word, big-endian (first byte in [31:24]).
- `valid_i` in 1: `data_i` is valid.
- `last_i` in 1: this word is the final word of the message.
- `last_bytes_i` in 3: number of valid bytes in the final word, 0..4. Only left-aligned bytes count. Values above 4 are treated as 4.
- `ready_o` out 1: engine accepts a word this cycle.
- `busy_o` out 1: engine is not in IDLE.
- `done_o` out 1: one-cycle pulse; the digest is valid.
- `result_o` out 160: digest H0..H4, with H0 in [159:128].
- `tag_o` out TAG_W: latched tag, valid alongside `result_o`.

## Operation
- States: IDLE, LOAD, PAD, HASH, UPDATE, DONE.
- **IDLE**
  - `start_i` latches the tag, loads H = 67452301 EFCDAB89 98BADCFE 10325476 C3D2E1F0, clears the word index and the length counter, and moves to LOAD.
  - `ready_o` is low in IDLE, so a `valid_i` in the same cycle as `start_i` is not consumed.
- **LOAD**
  - A word transfers when `valid_i` and `ready_o` are both high; `ready_o` is high only in LOAD.
  - Each transfer writes W[idx] and adds 32 to the length counter; the final word adds 8×`last_bytes_i` instead.
  - The length counter wraps modulo 2^LEN_W.
  - 16th word transferred and not last: go to HASH.
  - Last word transferred: go to PAD.
- **PAD** (one cycle) builds the padded block:
  - Invalid bytes of the final word are zeroed.
  - Byte 0x80 goes at byte offset 4k+n, where k is the word index and n is `last_bytes_i`. Zeros follow.
  - If the 0x80 lands in word 13 or earlier, words 14 and 15 receive the 64-bit length, and `final` is set.
  - Otherwise the remainder of the block is zero and `extra` is set. An extra block is words 0..13 zero, words 14..15 the length, with 0x80 in word 0 only if it did not fit in the first block.
- **HASH**
  - Runs 80/ROUNDS_PER_CYCLE cycles, each applying ROUNDS_PER_CYCLE chained rounds.
  - The schedule is a 16-entry circular buffer: W[t] = rotl1(W[t-3]^W[t-8]^W[t-14]^W[t-16]).
  - f/K selection: Ch/5A827999 for rounds 0–19, Parity/6ED9EBA1 for 20–39, Maj/8F1BBCDC for 40–59, Parity/CA62C1D6 for 60–79. All arithmetic is mod 2^32.
- **UPDATE**: H_i += {a,b,c,d,e}. Then:
  - `extra` pending: go to PAD to build the extra block.
  - `final`: go to DONE.
  - Otherwise: go to LOAD with the word index at 0.
- **DONE**: `done_o` = 1 for one cycle; `result_o` and `tag_o` are registered from H. Then go to IDLE.
- `result_o` and `tag_o` hold their value until the next DONE or reset.
- **Reset** (including mid-operation): go to IDLE. All outputs read 0: `ready_o`, `busy_o`, `done_o`, `result_o`, `tag_o`.

## Timing
- Let R = 80/ROUNDS_PER_CYCLE.
- `start_i` sampled at edge N: `ready_o` = 1 from cycle N+1.
- Last word accepted at edge M, single padded block: `done_o` is high in cycle M+R+3 (PAD, R HASH cycles, UPDATE, then DONE).
- An extra padding block adds R+2 cycles.
- A full non-final block: from the 16th accepted word to `ready_o` high again takes R+2 cycles.
- `busy_o` is high from N+1 through the DONE cycle, inclusive.

## Structure
- Shared package `sha1_pkg`:
  - IV constants and round constants K0..K3.
  - State enum.
  - Function `sha1_f(t, b, c, d)`.
- Sub-module `sha1_round`: combinational, one round. Inputs are a..e, W and the round index t; output is the next a..e. It is instantiated ROUNDS_PER_CYCLE times in a chain.

## Test plan
- **"abc"**: one word 0x61626300 with last_bytes = 3, at ROUNDS_PER_CYCLE = 1, 4 and 20.
  - Expect `result_o` = a9993e36 4706816a ba3e2571 7850c26c 9cd0d89d.
  - Expect `done_o` exactly R+3 cycles after the last word is accepted.
- **Empty message**: one word with last = 1 and last_bytes = 0.
  - Expect da39a3ee 5e6b4b0d 3255bfef 95601890 afd80709.
- **"1234"**: 0x31323334 with last_bytes = 4 and tag 0x10001000.
  - Expect 7110eda4 d09e062a a5e4a390 b0a572ac 0d2c0220 with `tag_o` = 0x10001000.
- **56-byte "abcdbcde…nopq"**: 14 words, last_bytes = 4, which forces an extra block.
  - Expect 84983e44 1c3bd26e baae4aa1 f95129e5 e54670f1.
  - Expect `done_o` 2R+5 cycles after the last word.
- **Backpressure and illegal starts**: gap `valid_i` randomly, and pulse `start_i` while busy.
  - Expect the digest unchanged, `start_i` ignored, and no word accepted while `ready_o` = 0.
- **Reset mid-HASH**: assert `rst` mid-HASH.
  - Next cycle: all outputs 0 and the engine in IDLE.
  - A subsequent "abc" run produces the correct digest.
